vppm_frame_deser: RTL and testbench
===================================

Name: vppm_frame_deser

Overview:
- Sits directly downstream of the frequency-locked VPPM demodulator, in the clk_200 domain.
- Consumes the demodulated serial bit stream and hunts for the preamble: at least MIN_ZEROS '0' bits followed by a single '1' sync bit.
- After sync it deserializes NBITS-bit data words, MSB first.
- Each word is presented on a one-deep output register with a valid/ready handshake. Framing loss is flagged via syncLocked and overrun.

Parameters:
- NBITS, 12, data word width in bits.
- MIN_ZEROS, 5, minimum consecutive '0' bits before the sync '1' is accepted.
- CONTINUOUS, 1. When 1, stay in DATA after each word (infinite demodulation). When 0, return to HUNT after each word.

Ports:
- clk, input, 1, system clock (200 MHz demodulator clock).
- rst, input, 1, asynchronous active-high reset.
- bitIn, input, 1, demodulated bit value; qualified by bitValid.
- bitValid, input, 1, single-cycle strobe, one per received VPPM symbol.
- freqLock, input, 1, demodulator frequency-available flag. Low aborts framing.
- wordOut, output, NBITS, deserialized word, MSB = first received data bit.
- wordValid, output, 1, wordOut holds an unconsumed word.
- wordReady, input, 1, consumer accepts wordOut when wordValid && wordReady.
- syncLocked, output, 1, high while in DATA state.
- overrun, output, 1, sticky: a completed word was dropped.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, state = HUNT, zero counter = 0, bit counter = 0, shift register = 0.
- Only cycles with bitValid=1 advance framing. With bitValid=0, all framing state holds.
- HUNT: zero counter saturates at MIN_ZEROS.
  - bitIn=0 → counter increments.
  - bitIn=1 with counter < MIN_ZEROS → counter clears, stay in HUNT.
  - Counter reaching MIN_ZEROS → go to SYNC.
- SYNC:
  - bitIn=0 → stay in SYNC (extra zeros allowed).
  - bitIn=1 → DATA, bit counter = 0. The sync bit itself is not stored.
- DATA:
  - Each valid bit: shift register <= {shift[NBITS-2:0], bitIn}, bit counter increments.
  - On the NBITS-th bit: word complete, bit counter = 0.
  - Next state is DATA if CONTINUOUS=1, else HUNT with zero counter = 0.
- syncLocked is registered and equals (state == DATA).
- Word completion on cycle N (the last bit's bitValid cycle) → wordOut/wordValid update on edge N+1. Latency is 1 clock from the last bit strobe.
- Handshake:
  - wordValid stays high until a cycle with wordReady=1; wordValid clears on that edge.
  - wordOut is stable while wordValid=1.
- Completion while wordValid=1 and wordReady=0: new word dropped, wordOut unchanged, overrun set to 1. overrun clears only on rst.
- Completion in the same cycle as an accept (wordValid && wordReady): new word loaded, wordValid remains 1, no overrun.
- freqLock=0 on any cycle (priority over bitValid):
  - state → HUNT; zero counter, bit counter and shift register cleared; syncLocked → 0 next edge.
  - Partial words are discarded. wordOut, wordValid and overrun are unaffected.
- Counter widths: bit counter ceil(log2(NBITS+1)) bits; zero counter ceil(log2(MIN_ZEROS+1)) bits. No wrap is possible because both saturate or reset at bound.
- Mid-operation rst: immediate return to reset values regardless of state or pending word.

Test Plan:
- freqLock=1, wordReady=1, bits 00000 1 101010101010 → wordOut=12'hAAA, wordValid pulse 1 cycle, 1 clock after the 18th bitValid; syncLocked=1 from the edge after the sync bit.
- Bits 0000 1 00000 1 111100001111 → first '1' rejected (only 4 zeros), second accepted; wordOut=12'hF0F.
- CONTINUOUS=1, wordReady=0, after sync send 12'h123 then 12'h456 → wordOut stays 12'h123, overrun=1. Raise wordReady → wordValid falls; overrun stays 1.
- wordReady asserted exactly on the completion cycle of a second word (12'h0FF then 12'hF00) → wordOut=12'hF00, wordValid stays 1, overrun=0.
- freqLock dropped after 6 data bits → syncLocked=0, no word emitted. After re-sync with 00000 1 + 12'h555 → wordOut=12'h555.
- rst pulsed mid-word with wordValid=1 → all outputs 0 asynchronously; next frame 00000 1 + 12'hFFF decodes to 12'hFFF.

Source files
------------

// File: rtl/vppm_frame_deser.sv
// VPPM frame deserializer: hunts for a run of zeros followed by a sync '1',
// then shifts in NBITS-bit words MSB first and hands each word to a
// one-deep valid/ready output register. Loss of frequency lock aborts
// framing without disturbing a word already waiting at the output.
module vppm_frame_deser #(
    parameter int NBITS      = 12,
    parameter int MIN_ZEROS  = 5,
    parameter int CONTINUOUS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bitIn,
    input  logic             bitValid,
    input  logic             freqLock,
    output logic [NBITS-1:0] wordOut,
    output logic             wordValid,
    input  logic             wordReady,
    output logic             syncLocked,
    output logic             overrun
);

    localparam int ZW = $clog2(MIN_ZEROS + 1);
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ZW-1:0]    zcnt_q, zcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    // Only the NBITS-1 most recent data bits need storing; the final bit of a
    // word comes straight from bitIn on the completion cycle.
    logic [NBITS-2:0] shift_q, shift_d;
    logic [NBITS-1:0] word_out_q, word_out_d;
    logic             word_valid_q, word_valid_d;
    logic             overrun_q, overrun_d;
    logic             sync_locked_q, sync_locked_d;
    logic [NBITS-1:0] word_s;
    logic             word_done_s;

    assign word_s = {shift_q, bitIn};

    // Framing FSM: preamble hunt, sync detection and data bit counting.
    always_comb begin
        state_d     = state_q;
        zcnt_d      = zcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        word_done_s = 1'b0;
        if (!freqLock) begin
            state_d = HUNT;
            zcnt_d  = '0;
            bcnt_d  = '0;
            shift_d = '0;
        end else if (bitValid) begin
            case (state_q)
                HUNT: begin
                    if (!bitIn) begin
                        zcnt_d = zcnt_q + ZW'(1);
                        if (zcnt_q >= ZW'(MIN_ZEROS - 1)) begin
                            zcnt_d  = ZW'(MIN_ZEROS);
                            state_d = SYNC;
                        end else begin
                            state_d = HUNT;
                        end
                    end else begin
                        zcnt_d = '0;
                    end
                end
                SYNC: begin
                    if (bitIn) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                        zcnt_d  = '0;
                    end else begin
                        state_d = SYNC;
                    end
                end
                DATA: begin
                    shift_d = word_s[NBITS-2:0];
                    if (bcnt_q == BW'(NBITS - 1)) begin
                        word_done_s = 1'b1;
                        bcnt_d      = '0;
                        if (CONTINUOUS == 0) begin
                            state_d = HUNT;
                            zcnt_d  = '0;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    zcnt_d  = '0;
                    bcnt_d  = '0;
                    shift_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output register: load on completion when free or being drained, else flag overrun.
    always_comb begin
        word_out_d    = word_out_q;
        word_valid_d  = word_valid_q;
        overrun_d     = overrun_q;
        sync_locked_d = (state_d == DATA);
        if (word_done_s) begin
            if (!word_valid_q || wordReady) begin
                word_out_d   = word_s;
                word_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (word_valid_q && wordReady) begin
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            zcnt_q        <= '0;
            bcnt_q        <= '0;
            shift_q       <= '0;
            word_out_q    <= '0;
            word_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            sync_locked_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            zcnt_q        <= zcnt_d;
            bcnt_q        <= bcnt_d;
            shift_q       <= shift_d;
            word_out_q    <= word_out_d;
            word_valid_q  <= word_valid_d;
            overrun_q     <= overrun_d;
            sync_locked_q <= sync_locked_d;
        end
    end

    assign wordOut    = word_out_q;
    assign wordValid  = word_valid_q;
    assign overrun    = overrun_q;
    assign syncLocked = sync_locked_q;

endmodule

// File: tb/tb_vppm_frame_deser.sv
// Scoreboard bench for vppm_frame_deser: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted handshake.
module tb_vppm_frame_deser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bitIn = 1'b0;
    logic        bitValid = 1'b0;
    logic        freqLock = 1'b1;
    logic [11:0] wordOut;
    logic        wordValid;
    logic        wordReady = 1'b0;
    logic        syncLocked;
    logic        overrun;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];

    vppm_frame_deser #(.NBITS(12), .MIN_ZEROS(5), .CONTINUOUS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .bitIn     (bitIn),
        .bitValid  (bitValid),
        .freqLock  (freqLock),
        .wordOut   (wordOut),
        .wordValid (wordValid),
        .wordReady (wordReady),
        .syncLocked(syncLocked),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && wordValid && wordReady) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL word_accept: got %03h, scoreboard empty", wordOut);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (wordOut !== e) begin
                    n_err++;
                    $display("FAIL word_accept: got %03h expected %03h", wordOut, e);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One idle cycle, then one bit strobe; returns just after the sampling edge.
    task automatic send_bit(input logic b, input logic rdy_with_bit);
        bitValid = 1'b0;
        @(posedge clk); #1;
        bitIn    = b;
        bitValid = 1'b1;
        if (rdy_with_bit) wordReady = 1'b1;
        @(posedge clk); #1;
        bitValid = 1'b0;
        bitIn    = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] w, input logic rdy_last, input logic push);
        if (push) exp_q.push_back(w);
        for (int i = 11; i >= 0; i--) send_bit(w[i], rdy_last && (i == 0));
    endtask

    task automatic send_sync(input int zeros);
        for (int i = 0; i < zeros; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_wordValid", {31'd0, wordValid}, 32'd0);
        chk("rst_wordOut", {20'd0, wordOut}, 32'd0);
        chk("rst_syncLocked", {31'd0, syncLocked}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // Test 1: basic frame 00000 1 AAA, latency and one-cycle valid pulse.
        do_reset();
        freqLock  = 1'b1;
        wordReady = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        chk("t1_unlocked_before_sync", {31'd0, syncLocked}, 32'd0);
        send_bit(1'b1, 1'b0);
        chk("t1_locked_after_sync", {31'd0, syncLocked}, 32'd1);
        chk("t1_no_word_yet", {31'd0, wordValid}, 32'd0);
        send_word(12'hAAA, 1'b0, 1'b1);
        chk("t1_valid_latency", {31'd0, wordValid}, 32'd1);
        chk("t1_wordOut", {20'd0, wordOut}, 32'h0AAA);
        @(posedge clk); #1;
        chk("t1_valid_pulse_end", {31'd0, wordValid}, 32'd0);

        // Test 2: four zeros are not enough, five are.
        do_reset();
        wordReady = 1'b1;
        send_sync(4);
        chk("t2_short_preamble_rejected", {31'd0, syncLocked}, 32'd0);
        send_sync(5);
        chk("t2_long_preamble_locked", {31'd0, syncLocked}, 32'd1);
        send_word(12'hF0F, 1'b0, 1'b1);
        chk("t2_valid", {31'd0, wordValid}, 32'd1);

        // Test 3: overrun when a second word completes with no consumer.
        do_reset();
        wordReady = 1'b0;
        send_sync(5);
        send_word(12'h123, 1'b0, 1'b1);
        chk("t3_first_valid", {31'd0, wordValid}, 32'd1);
        chk("t3_no_overrun_yet", {31'd0, overrun}, 32'd0);
        send_word(12'h456, 1'b0, 1'b0);
        chk("t3_overrun_set", {31'd0, overrun}, 32'd1);
        chk("t3_wordOut_held", {20'd0, wordOut}, 32'h0123);
        wordReady = 1'b1;
        @(posedge clk); #1;
        chk("t3_valid_falls", {31'd0, wordValid}, 32'd0);
        chk("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Test 4: accept coincides with completion of the next word.
        do_reset();
        wordReady = 1'b0;
        send_sync(5);
        send_word(12'h0FF, 1'b0, 1'b1);
        send_word(12'hF00, 1'b1, 1'b1);
        wordReady = 1'b0;
        chk("t4_wordOut_new", {20'd0, wordOut}, 32'h0F00);
        chk("t4_valid_kept", {31'd0, wordValid}, 32'd1);
        chk("t4_no_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;
        wordReady = 1'b1;
        @(posedge clk); #1;
        chk("t4_drained", {31'd0, wordValid}, 32'd0);

        // Test 5: frequency lock lost mid-word discards the partial word.
        do_reset();
        wordReady = 1'b1;
        send_sync(5);
        for (int i = 0; i < 6; i++) send_bit(i[0], 1'b0);
        freqLock = 1'b0;
        @(posedge clk); #1;
        freqLock = 1'b1;
        chk("t5_unlocked", {31'd0, syncLocked}, 32'd0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        chk("t5_no_word", {31'd0, wordValid}, 32'd0);
        chk("t5_still_unlocked", {31'd0, syncLocked}, 32'd0);
        send_sync(5);
        send_word(12'h555, 1'b0, 1'b1);
        chk("t5_resync_valid", {31'd0, wordValid}, 32'd1);
        chk("t5_resync_word", {20'd0, wordOut}, 32'h0555);
        @(posedge clk); #1;

        // Test 6: asynchronous reset mid-word with a pending word and overrun.
        do_reset();
        wordReady = 1'b0;
        send_sync(5);
        send_word(12'hA5A, 1'b0, 1'b1);
        send_word(12'h3C3, 1'b0, 1'b0);
        chk("t6_pre_overrun", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_wordValid", {31'd0, wordValid}, 32'd0);
        chk("t6_async_wordOut", {20'd0, wordOut}, 32'd0);
        chk("t6_async_syncLocked", {31'd0, syncLocked}, 32'd0);
        chk("t6_async_overrun", {31'd0, overrun}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wordReady = 1'b1;
        @(posedge clk); #1;
        send_sync(5);
        send_word(12'hFFF, 1'b0, 1'b1);
        chk("t6_after_reset_word", {20'd0, wordOut}, 32'h0FFF);
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
